uart_rx_8n1: RTL
================

Name: uart_rx_8n1

Overview:
- Receiver stage that sits directly downstream of the UART transmitter.
- Samples the serial line, recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop, no parity) and presents each byte with a one-cycle valid strobe.
- Flags framing errors.
- Used for TX→RX loopback on the board and as the serial input of the lab designs.

Parameters:
- CLK_FREQ, 1_152_000, system clock frequency in Hz.
- BAUD_RATE, 115_200, line bit rate in bits/s.
- CLKS_PER_BIT (localparam), CLK_FREQ/BAUD_RATE (default 10), clocks per bit; must be ≥4.
- HALF_BIT (localparam), CLKS_PER_BIT/2 (default 5), offset to the middle of a bit.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  reset, asynchronous, active-high.
- Din  input  1  serial line; idles high; asynchronous to CLK.
- Dout  output  8  last correctly received byte.
- Valid  output  1  one-cycle pulse when Dout is updated.
- Frame_err  output  1  one-cycle pulse when the stop bit samples low.
- Busy  output  1  high while a frame is being received (state ≠ IDLE).

Behaviour:
- Reset (async, RST=1):
  - state=IDLE, bit counter=0, clock counter=0, shift register=0x00.
  - Dout=0x00, Valid=0, Frame_err=0, Busy=0.
  - Synchronizer flops and previous-sample flop=1, so no false edge is seen on reset release.
- Input synchronization: Din passes through a 2-flop synchronizer, giving rx_s. All decisions use rx_s only.
- Falling-edge detect: fall = prev_rx_s & ~rx_s.
- IDLE:
  - Busy=0.
  - On fall: go to START, clock counter=0.
  - A line held low does not retrigger, because a new edge is required.
- START:
  - Count clocks. When counter==HALF_BIT-1, sample rx_s.
  - rx_s=0: go to DATA, counter=0, bit index=0.
  - rx_s=1: glitch; return to IDLE with no outputs asserted.
- DATA:
  - Count 0..CLKS_PER_BIT-1. At CLKS_PER_BIT-1, shift rx_s into the MSB of the shift register (right shift, so the first bit ends at bit 0), then counter=0 and bit index+1.
  - After the 8th sample, go to STOP.
- STOP:
  - Count 0..CLKS_PER_BIT-1. At CLKS_PER_BIT-1, sample rx_s.
  - rx_s=1: Dout<=shift register and Valid=1 for exactly one cycle.
  - rx_s=0: Frame_err=1 for exactly one cycle and Dout unchanged.
  - Either way, next state is IDLE.
- Latency (default parameters): Valid/Frame_err rises 97 clocks after the first CLK edge that sees Din low. Bench tolerance is ±1 clock.
- Back-to-back frames: IDLE is re-entered mid stop-bit, so a start edge arriving immediately after the stop bit is caught. No dead time beyond half a bit.
- Valid and Frame_err are never high in the same cycle; they are never high outside the cycle following a stop-bit sample.
- Dout holds its value until the next valid frame.
- Reset mid-frame: all state returns to reset values immediately; the partial byte is discarded and no Valid is emitted.
- There is no receive buffer. The consumer must take Dout on Valid; overwrite by the next frame is permitted.

Test Plan:
- Bench drives 0x55 at 10 clocks/bit (start 0, bits 1,0,1,0…, stop 1) -> Valid pulses once 97±1 clocks after the start edge; Dout=0x55; Frame_err stays 0; Busy high for the frame and then 0.
- 0xA5 followed immediately by 0x3C with no idle gap -> two Valid pulses 100±1 clocks apart; Dout=0xA5 then 0x3C.
- Din low for 3 clocks, then high -> Busy rises then falls within 8 clocks; no Valid; no Frame_err; Dout unchanged.
- Frame 0x7E with stop bit forced 0 -> Frame_err single-cycle pulse; Valid stays 0; Dout retains the previous 0x3C; Din then held low for 200 clocks -> no further activity until the line returns high and falls again.
- RST asserted for 2 clocks during data bit 4 of 0xC3 -> Busy=0 and Dout=0x00 immediately; no Valid. A subsequent clean 0xC3 -> Dout=0xC3.
- Loopback: transmitter Dout wired to Din, both at CLK_FREQ=1_152_000; transmitter sends its frame for SW=4'b0001, then SW=4'b0010 -> one Valid per frame; Dout equals the byte transmitted each time; no Frame_err.

Source files
------------

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 2-flop input synchronizer, start-edge detect, mid-bit
// sampling, one-cycle Valid / Frame_err strobes on the stop-bit decision.
module uart_rx_8n1 #(
   parameter int CLK_FREQ  = 1_152_000,
   parameter int BAUD_RATE = 115_200
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       Din,
   output logic [7:0] Dout,
   output logic       Valid,
   output logic       Frame_err,
   output logic       Busy
);

   // CLKS_PER_BIT must be at least 4 for the half-bit start check to make sense.
   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic             sync1_q, rx_s_q, prev_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       dout_q, dout_d;
   logic             valid_q, valid_d;
   logic             frame_err_q, frame_err_d;

   logic fall;
   logic bit_end;

   assign fall    = prev_q & ~rx_s_q;
   assign bit_end = (cnt_q == BIT_LAST);

   // State register.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values of its neighbours, independent of statement order.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath registers. Synchronizer and edge flops reset to the idle line
   // level so reset release never looks like a start edge.
   // NOTE: every flop here is a plain register (no RAM), so all of them get a
   // reset value; the async reset clears a partial frame immediately.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync1_q     <= 1'b1;
         rx_s_q      <= 1'b1;
         prev_q      <= 1'b1;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         dout_q      <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         sync1_q     <= Din;
         rx_s_q      <= sync1_q;
         prev_q      <= rx_s_q;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         dout_q      <= dout_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   // Next-state and counter logic.
   // NOTE: every signal gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + CNT_W'(1);
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (fall) state_d = START;
         end
         START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d     = '0;
               bit_idx_d = '0;
               state_d   = rx_s_q ? IDLE : DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_d     = '0;
               shift_d   = {rx_s_q, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) state_d = STOP;
            end
         end
         STOP: begin
            // Leaving mid stop-bit leaves room to catch an immediate next start.
            if (bit_end) begin
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output decode: stop-bit decision drives the registered strobes.
   always_comb begin
      valid_d     = 1'b0;
      frame_err_d = 1'b0;
      dout_d      = dout_q;
      if (state_q == STOP && bit_end) begin
         valid_d     = rx_s_q;
         frame_err_d = ~rx_s_q;
      end
      if (valid_d) dout_d = shift_q;
   end

   assign Dout      = dout_q;
   assign Valid     = valid_q;
   assign Frame_err = frame_err_q;
   assign Busy      = (state_q != IDLE);

endmodule
